// File: rtl/can_error_frame_tx.sv
// rtl/can_error_frame_tx.sv - CAN error frame transmitter: flag, wait for recessive bus, 8-bit delimiter
module can_error_frame_tx #(
  parameter int CLKS_PER_BIT  = 10,
  parameter int MAX_WAIT_BITS = 8
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_form_error,
  input  logic       i_crc_error,
  input  logic       i_stuff_error,
  input  logic       i_bit_error,
  input  logic       i_error_passive,
  input  logic       i_Data,
  output logic       o_Tx,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_bus_stuck,
  output logic [3:0] o_err_code
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int DW = $clog2(MAX_WAIT_BITS + 1);
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID_CLK  = CW'(CLKS_PER_BIT / 2);
  localparam logic [DW-1:0] DOM_LAST = DW'(MAX_WAIT_BITS - 1);

  typedef enum logic [1:0] {IDLE, FLAG, WAIT_REC, DELIM} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0] dom_cnt_q, dom_cnt_d;
  logic [3:0]    delim_cnt_q, delim_cnt_d;
  logic          passive_q, passive_d;
  logic [3:0]    err_code_q, err_code_d;
  logic          sync1_q, sync2_q;
  logic          trigger, bit_end, mid_bit, done, stuck;

  assign trigger = i_form_error | i_crc_error | i_stuff_error | i_bit_error;
  assign bit_end = (clk_cnt_q == LAST_CLK);
  assign mid_bit = (clk_cnt_q == MID_CLK);

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = bit_end ? '0 : clk_cnt_q + 1'b1;
    bit_cnt_d   = bit_cnt_q;
    dom_cnt_d   = dom_cnt_q;
    delim_cnt_d = delim_cnt_q;
    passive_d   = passive_q;
    err_code_d  = err_code_q;
    done        = 1'b0;
    stuck       = 1'b0;
    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (trigger) begin
          state_d     = FLAG;
          bit_cnt_d   = '0;
          dom_cnt_d   = '0;
          delim_cnt_d = '0;
          passive_d   = i_error_passive;
          err_code_d  = {i_form_error, i_crc_error, i_stuff_error, i_bit_error};
        end
      end
      FLAG: begin
        if (bit_end) begin
          if (bit_cnt_q == 3'd5) state_d = WAIT_REC;
          else bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      WAIT_REC: begin
        if (mid_bit) begin
          if (sync2_q) begin
            state_d     = DELIM;
            delim_cnt_d = 4'd1;
            clk_cnt_d   = '0;
          end else if (dom_cnt_q == DOM_LAST) begin
            stuck     = 1'b1;
            state_d   = IDLE;
            dom_cnt_d = dom_cnt_q + 1'b1;
            clk_cnt_d = '0;
          end else begin
            dom_cnt_d = dom_cnt_q + 1'b1;
          end
        end
      end
      DELIM: begin
        // A dominant sample means another node is still flagging: resync, keep the dominant tally.
        if (mid_bit && !sync2_q) begin
          state_d     = WAIT_REC;
          delim_cnt_d = '0;
          clk_cnt_d   = '0;
        end else if (bit_end) begin
          if (delim_cnt_q == 4'd8) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            delim_cnt_d = delim_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      dom_cnt_q   <= '0;
      delim_cnt_q <= '0;
      passive_q   <= 1'b0;
      err_code_q  <= 4'b0000;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      dom_cnt_q   <= dom_cnt_d;
      delim_cnt_q <= delim_cnt_d;
      passive_q   <= passive_d;
      err_code_q  <= err_code_d;
      sync1_q     <= i_Data;
      sync2_q     <= sync1_q;
    end
  end

  assign o_Tx        = !((state_q == FLAG) && !passive_q);
  assign o_busy      = (state_q != IDLE);
  assign o_done      = done;
  assign o_bus_stuck = stuck;
  assign o_err_code  = err_code_q;

endmodule
